piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in serial-out transmitter that pairs with the team's mode-controlled serial-in parallel-out shift register. It accepts a WIDTH-bit word over a valid/ready handshake and serializes it one bit per bit period. For each bit it drives a data bit plus a 2-bit mode code, and the receiving shift register consumes that code directly. When a frame completes, the receiver's parallel output equals the transmitted word.

## Interface
- WIDTH, 8, word width in bits (≥2)
- BIT_CYCLES, 1, clock cycles per serial bit (≥1)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; overrides all other inputs
- par_i  input  WIDTH  parallel word to send; sampled only at accept
- dir_i  input  1  bit order, sampled at accept: 0 = MSB first (receiver left-shift), 1 = LSB first (receiver right-shift)
- valid_i  input  1  producer has a word on par_i
- ready_o  output  1  transmitter can accept a word (high only in IDLE)
- ser_o  output  1  serial data bit, wired to receiver D
- mode_o  output  2  receiver mode: 2'b00 hold, 2'b10 left, 2'b11 right; 2'b01 (load) is never driven
- busy_o  output  1  high in SHIFT
- done_o  output  1  one-cycle pulse after the last bit's final cycle

## Operation
- FSM states and transitions:
  - IDLE → SHIFT on accept (valid_i && ready_o at a clock edge).
  - SHIFT → DONE after bit WIDTH-1 completes its BIT_CYCLES-th cycle.
  - DONE → IDLE unconditionally.
- Accept captures par_i into an internal shift register, captures dir_i, and clears the bit counter (0..WIDTH-1) and the cycle counter (0..BIT_CYCLES-1).
- SHIFT drives ser_o with the current bit: shreg[WIDTH-1] if dir=0, shreg[0] if dir=1.
  - ser_o holds for all BIT_CYCLES cycles of a bit.
  - The shift register advances (left if dir=0, right if dir=1) when the cycle counter wraps.
- mode_o = 2'b10 (dir=0) or 2'b11 (dir=1) only in the final cycle of each bit period (cycle counter == BIT_CYCLES-1). It is 2'b00 in all other cycles and states. The receiver therefore samples exactly once per bit.
- IDLE and DONE: ser_o=0, mode_o=2'b00, busy_o=0.
- DONE: done_o=1, ready_o=0.
- Changes on par_i, dir_i, or valid_i during SHIFT or DONE are ignored.
- The counters are sized to hold their maximum values. Wrap-around occurs only at the defined terminal counts.

## Timing
- Reset: the first edge with rst=1 forces IDLE. Outputs are then ready_o=1, ser_o=0, mode_o=2'b00, busy_o=0, done_o=0, and all counters and the shift register are 0.
- Reset mid-frame aborts the frame at the next edge. No done_o pulse is produced, and the next accept starts a fresh frame.
- If rst and valid_i are both high at the same edge, reset wins and nothing is accepted.
- Accept at edge k. From cycle k+1, bit 0 appears on ser_o and busy_o=1.
- The frame occupies WIDTH×BIT_CYCLES cycles.
  - mode_o strobes occur at cycles k+BIT_CYCLES, k+2·BIT_CYCLES, …, k+WIDTH·BIT_CYCLES.
  - done_o is high in cycle k+WIDTH·BIT_CYCLES+1.
  - ready_o returns to 1 in the following cycle.
- Minimum accept-to-accept spacing is WIDTH·BIT_CYCLES+2 cycles. A valid_i held high continuously produces back-to-back frames at that rate.
- All outputs are registered or decoded purely from registered state. There is no combinational path from any input to any output except ready_o, which is decoded from state only.

## Test plan
- Reset: hold rst=1 for 2 edges with valid_i=1 and par_i=8'h77 -> ready_o=1, mode_o=0, ser_o=0, busy_o=0, and no frame starts.
- MSB-first, BIT_CYCLES=1: send 8'hAA with dir=0 -> ser_o sequence 1,0,1,0,1,0,1,0 with mode_o=2'b10 in each of 8 cycles. done_o pulses once, and the attached shift register holds P=8'hAA.
- LSB-first: send 8'hAA with dir=1 -> ser_o sequence 0,1,0,1,0,1,0,1 with mode_o=2'b11. The receiver holds P=8'hAA.
- BIT_CYCLES=3: send 8'hC3 with dir=0 -> each bit held for 3 cycles, mode_o nonzero only in every third cycle (8 strobes total), done_o at accept+25, and receiver P=8'hC3.
- Back-to-back: valid_i held high with 8'h0F then 8'hF0 -> second accept exactly 10 cycles after the first. par_i changes during the first frame do not affect it, and the receiver ends at 8'hF0.
- Reset mid-frame: assert rst after 4 bits of 8'hFF -> IDLE at the next edge, no done_o pulse, and ready_o=1. A new 8'h5A frame then completes correctly.

Source files
------------

// File: rtl/piso_tx_if.sv
// piso_tx_if: word handshake, serial data and receiver-mode bundle for piso_tx.
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] par_i;
    logic             dir_i;
    logic             valid_i;
    logic             ready_o;
    logic             ser_o;
    logic [1:0]       mode_o;
    logic             busy_o;
    logic             done_o;

    // Transmitter side: consumes words, drives the serial link and status.
    modport slave (
        input  par_i, dir_i, valid_i,
        output ready_o, ser_o, mode_o, busy_o, done_o
    );

    // Producer / receiver side: offers words, observes the serial link.
    modport master (
        output par_i, dir_i, valid_i,
        input  ready_o, ser_o, mode_o, busy_o, done_o
    );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter. Each accepted word is sent one bit
// per BIT_CYCLES clocks, with a one-cycle receiver mode strobe closing each bit.
module piso_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic     clk,
    input  logic     rst,
    piso_tx_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q,   dir_d;
    logic [BW-1:0]    bit_q,   bit_d;
    logic [CW-1:0]    cyc_q,   cyc_d;

    // Final cycle of the current bit period; the receiver samples only here.
    logic bit_end;
    assign bit_end = (state_q == SHIFT) && (cyc_q == CYC_LAST);

    // Next-state and datapath update logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        shreg_d = shreg_q;
        dir_d   = dir_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q;

        unique case (state_q)
            IDLE: begin
                // ready_o is high throughout IDLE, so valid_i alone means accept.
                if (bus.valid_i) begin
                    state_d = SHIFT;
                    shreg_d = bus.par_i;
                    dir_d   = bus.dir_i;
                    bit_d   = '0;
                    cyc_d   = '0;
                end
            end

            SHIFT: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    shreg_d = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
                    if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            // NOTE: the shift register is cleared too, so an aborted frame leaves no stale data.
            shreg_q <= '0;
            dir_q   <= 1'b0;
            bit_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dir_q   <= dir_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
        end
    end

    // Outputs decoded purely from registered state.
    assign bus.ready_o = (state_q == IDLE);
    assign bus.busy_o  = (state_q == SHIFT);
    assign bus.done_o  = (state_q == DONE);
    assign bus.ser_o   = (state_q == SHIFT) && (dir_q ? shreg_q[0] : shreg_q[WIDTH-1]);
    assign bus.mode_o  = bit_end ? (dir_q ? MODE_RIGHT : MODE_LEFT) : MODE_HOLD;

    // Load mode is reserved for the receiver's own use and must never be driven.
    a_no_load_mode: assert property (@(posedge clk) bus.mode_o != 2'b01);

    // Handshake and status are mutually exclusive.
    a_busy_not_ready: assert property (@(posedge clk) !(bus.busy_o && bus.ready_o));
    a_done_not_ready: assert property (@(posedge clk) !(bus.done_o && bus.ready_o));

    // A completed frame always returns to IDLE on the next edge.
    a_done_to_idle: assert property (@(posedge clk) bus.done_o |=> bus.ready_o);
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx. Lane 0 runs BIT_CYCLES=1, lane 1
// runs BIT_CYCLES=3; each lane has a receiver model and an output monitor.
module tb_piso_tx;
    localparam int WIDTH = 8;

    typedef struct {
        bit         is_done;
        logic [1:0] mode;
        logic       ser;
        logic [7:0] p;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]            rst   = 2'b11;
    logic [1:0]            valid = 2'b00;
    logic [1:0]            dir   = 2'b00;
    logic [1:0][WIDTH-1:0] par   = '0;

    logic [1:0]            ready, ser, busy, done;
    logic [1:0][1:0]       mode;

    exp_t exp_q   [2][$];
    int   acc_log [2][$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int BC = (g == 0) ? 1 : 3;

        piso_tx_if #(.WIDTH(WIDTH)) bus ();

        assign bus.par_i   = par[g];
        assign bus.dir_i   = dir[g];
        assign bus.valid_i = valid[g];
        assign ready[g]    = bus.ready_o;
        assign ser[g]      = bus.ser_o;
        assign busy[g]     = bus.busy_o;
        assign done[g]     = bus.done_o;
        assign mode[g]     = bus.mode_o;

        piso_tx #(.WIDTH(WIDTH), .BIT_CYCLES(BC)) dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (bus)
        );

        // Receiver: mode-controlled shift register consuming mode_o/ser_o.
        logic [WIDTH-1:0] rx_p = '0;
        always @(posedge clk) begin
            case (bus.mode_o)
                2'b10:   rx_p <= {rx_p[WIDTH-2:0], bus.ser_o};
                2'b11:   rx_p <= {bus.ser_o, rx_p[WIDTH-1:1]};
                default: ;
            endcase
        end

        // Monitor: log accepts, pop the scoreboard on every strobe and done pulse.
        int   acc_cyc     = 0;
        int   n_ev        = 0;
        logic prev_busy   = 1'b0;
        logic prev_strobe = 1'b0;
        logic prev_ser    = 1'b0;
        always @(negedge clk) begin
            exp_t e;
            if (bus.valid_i && bus.ready_o && !rst[g]) begin
                acc_cyc = cyc + 1;
                acc_log[g].push_back(acc_cyc);
            end
            if (bus.busy_o && prev_busy && !prev_strobe)
                check($sformatf("L%0d ser hold", g), bus.ser_o, prev_ser);
            if (bus.mode_o != 2'b00) begin
                if (exp_q[g].size() == 0) begin
                    check($sformatf("L%0d unexpected strobe", g), bus.mode_o, 2'b00);
                end else begin
                    e = exp_q[g].pop_front();
                    n_ev++;
                    check($sformatf("L%0d ev%0d strobe mode", g, n_ev), bus.mode_o,
                          e.is_done ? 2'b00 : e.mode);
                    check($sformatf("L%0d ev%0d ser", g, n_ev), bus.ser_o, e.ser);
                    check($sformatf("L%0d ev%0d strobe cycle", g, n_ev), cyc + 1 - acc_cyc, e.lat);
                end
            end
            if (bus.done_o) begin
                if (exp_q[g].size() == 0) begin
                    check($sformatf("L%0d unexpected done", g), bus.done_o, 1'b0);
                end else begin
                    e = exp_q[g].pop_front();
                    n_ev++;
                    check($sformatf("L%0d ev%0d done", g, n_ev), bus.done_o, e.is_done);
                    check($sformatf("L%0d ev%0d rx P", g, n_ev), rx_p, e.p);
                    check($sformatf("L%0d ev%0d done cycle", g, n_ev), cyc + 1 - acc_cyc, e.lat);
                end
            end
            prev_busy   = bus.busy_o;
            prev_strobe = (bus.mode_o != 2'b00);
            prev_ser    = bus.ser_o;
        end
    end

    // Push nbits strobes (seq MSB = first bit on the wire) and optionally the done pulse.
    task automatic expect_frame(input int l, input logic [7:0] seq, input logic d, input int bc,
                                input int nbits, input bit with_done, input logic [7:0] p);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            e.is_done = 1'b0;
            e.mode    = d ? 2'b11 : 2'b10;
            e.ser     = seq[7-i];
            e.p       = '0;
            e.lat     = (i + 1) * bc;
            exp_q[l].push_back(e);
        end
        if (with_done) begin
            e.is_done = 1'b1;
            e.mode    = 2'b00;
            e.ser     = 1'b0;
            e.p       = p;
            e.lat     = WIDTH * bc + 1;
            exp_q[l].push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int l);
        for (int i = 0; i < 200 && !ready[l]; i++) step(1);
        if (!ready[l]) check($sformatf("L%0d ready timeout", l), ready[l], 1'b1);
    endtask

    task automatic wait_done(input int l);
        for (int i = 0; i < 200 && !done[l]; i++) step(1);
        check($sformatf("L%0d done seen", l), done[l], 1'b1);
        wait_ready(l);
    endtask

    task automatic send(input int l, input logic [7:0] w, input logic d);
        par[l]   = w;
        dir[l]   = d;
        valid[l] = 1'b1;
        step(1);
        valid[l] = 1'b0;
    endtask

    initial begin
        int base;

        // Reset held for two edges with a word offered: nothing may start.
        rst   = 2'b11;
        valid = 2'b11;
        par   = {8'h77, 8'h77};
        step(2);
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("rst L%0d ready", l), ready[l], 1'b1);
            check($sformatf("rst L%0d mode", l), mode[l], 2'b00);
            check($sformatf("rst L%0d ser", l), ser[l], 1'b0);
            check($sformatf("rst L%0d busy", l), busy[l], 1'b0);
            check($sformatf("rst L%0d done", l), done[l], 1'b0);
        end
        step(1);
        rst   = 2'b00;
        valid = 2'b00;
        step(2);
        check("post-rst L0 accepts", acc_log[0].size(), 0);
        check("post-rst L1 accepts", acc_log[1].size(), 0);

        // MSB first, BIT_CYCLES=1.
        expect_frame(0, 8'b1010_1010, 1'b0, 1, 8, 1'b1, 8'hAA);
        send(0, 8'hAA, 1'b0);
        wait_done(0);

        // LSB first, BIT_CYCLES=1.
        expect_frame(0, 8'b0101_0101, 1'b1, 1, 8, 1'b1, 8'hAA);
        send(0, 8'hAA, 1'b1);
        wait_done(0);

        // MSB first, BIT_CYCLES=3: done at accept+25.
        expect_frame(1, 8'b1100_0011, 1'b0, 3, 8, 1'b1, 8'hC3);
        send(1, 8'hC3, 1'b0);
        wait_done(1);

        // Back-to-back with valid held high; par changes mid-frame.
        base = acc_log[0].size();
        expect_frame(0, 8'b0000_1111, 1'b0, 1, 8, 1'b1, 8'h0F);
        expect_frame(0, 8'b1111_0000, 1'b0, 1, 8, 1'b1, 8'hF0);
        par[0]   = 8'h0F;
        dir[0]   = 1'b0;
        valid[0] = 1'b1;
        step(3);
        par[0] = 8'hF0;
        for (int i = 0; i < 40 && acc_log[0].size() < base + 2; i++) step(1);
        valid[0] = 1'b0;
        check("b2b accept count", acc_log[0].size(), base + 2);
        if (acc_log[0].size() >= base + 2)
            check("b2b spacing", acc_log[0][base+1] - acc_log[0][base], 10);
        wait_done(0);

        // Reset after 4 bits of 8'hFF: frame aborted, no done pulse.
        expect_frame(0, 8'b1111_1111, 1'b0, 1, 4, 1'b0, 8'h00);
        send(0, 8'hFF, 1'b0);
        step(3);
        rst[0] = 1'b1;
        step(1);
        check("abort ready", ready[0], 1'b1);
        check("abort busy", busy[0], 1'b0);
        check("abort done", done[0], 1'b0);
        check("abort mode", mode[0], 2'b00);
        rst[0] = 1'b0;
        step(12);
        check("abort strobes consumed", exp_q[0].size(), 0);

        // Fresh frame after the abort, LSB first.
        expect_frame(0, 8'b0101_1010, 1'b1, 1, 8, 1'b1, 8'h5A);
        send(0, 8'h5A, 1'b1);
        wait_done(0);

        step(5);
        check("L0 scoreboard empty", exp_q[0].size(), 0);
        check("L1 scoreboard empty", exp_q[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
